// File: rtl/md5_sched_pkg.sv
// md5_sched_pkg: shared constants, tag layout and feed-forward helpers for md5_stream_sched.
// Used by both the default build and the MD5_SCHED_STATS_EN build.
package md5_sched_pkg;

  localparam int SID_W_DFLT    = 2;
  localparam int PIPE_LAT_DFLT = 64;
  // Flag bits carried in every tag ahead of the stream id: valid, last.
  localparam int TAG_FLAG_W    = 2;

  localparam logic [31:0]  IV_A = 32'h67452301;
  localparam logic [31:0]  IV_B = 32'hefcdab89;
  localparam logic [31:0]  IV_C = 32'h98badcfe;
  localparam logic [31:0]  IV_D = 32'h10325476;
  localparam logic [127:0] IV   = {IV_A, IV_B, IV_C, IV_D};

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
  } md5_words_t;

  function automatic logic [127:0] pack_digest(input md5_words_t w);
    return {w.a, w.b, w.c, w.d};
  endfunction

  // Per-word modulo-2^32 sum of the chaining value and the core's round output.
  function automatic logic [127:0] ff_add(input md5_words_t chain, input md5_words_t rnd);
    md5_words_t s;
    s.a = chain.a + rnd.a;
    s.b = chain.b + rnd.b;
    s.c = chain.c + rnd.c;
    s.d = chain.d + rnd.d;
    return pack_digest(s);
  endfunction

endpackage

// File: rtl/md5_tag_delay.sv
// md5_tag_delay: fixed-depth tag shift register that tracks blocks through the MD5 core.
// A synchronous reset empties the line so nothing in flight is ever retired.
module md5_tag_delay
  import md5_sched_pkg::*;
#(
  parameter int W     = SID_W_DFLT + TAG_FLAG_W,
  parameter int DEPTH = PIPE_LAT_DFLT
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] tag_i,
  output logic [W-1:0] tag_o
);

  logic [W-1:0] line_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
    end else begin
      line_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
    end
  end

  assign tag_o = line_q[DEPTH-1];

endmodule

// File: rtl/md5_stream_sched.sv
// md5_stream_sched: interleaves up to 2**SID_W MD5 messages through a PIPE_LAT-deep core,
// keeps per-stream chaining state and emits digests. MD5_SCHED_STATS_EN adds stat counters.
module md5_stream_sched
  import md5_sched_pkg::*;
#(
  parameter int  SID_W     = SID_W_DFLT,
  parameter int  PIPE_LAT  = PIPE_LAT_DFLT,
  localparam int N_STREAMS = 2 ** SID_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [511:0]         in_data_i,
  input  logic [SID_W-1:0]     in_sid_i,
  input  logic                 in_first_i,
  input  logic                 in_last_i,
  output logic [511:0]         pipe_wb_o,
  output logic [31:0]          pipe_a0_o,
  output logic [31:0]          pipe_b0_o,
  output logic [31:0]          pipe_c0_o,
  output logic [31:0]          pipe_d0_o,
  input  logic [31:0]          pipe_a64_i,
  input  logic [31:0]          pipe_b64_i,
  input  logic [31:0]          pipe_c64_i,
  input  logic [31:0]          pipe_d64_i,
  output logic                 out_valid_o,
  output logic [SID_W-1:0]     out_sid_o,
  output logic [127:0]         out_digest_o,
  output logic [N_STREAMS-1:0] busy_o
`ifdef MD5_SCHED_STATS_EN
  ,
  output logic [31:0]          stat_blocks_o,
  output logic [31:0]          stat_digests_o,
  output logic [31:0]          stat_stalls_o
`endif
);

  localparam int TAG_W = SID_W + TAG_FLAG_W;

  typedef struct packed {
    logic             valid;
    logic             last;
    logic [SID_W-1:0] sid;
  } tag_t;

  logic [127:0]         ctx_q [N_STREAMS];
  logic [127:0]         ctx_d [N_STREAMS];
  logic [N_STREAMS-1:0] busy_q, busy_d;
  logic                 out_valid_q, out_valid_d;
  logic [SID_W-1:0]     out_sid_q, out_sid_d;
  logic [127:0]         out_digest_q, out_digest_d;

  logic                 accept;
  logic [127:0]         chain_in;
  logic [127:0]         exit_sum;
  tag_t                 tag_in;
  tag_t                 tag_out;
  logic [TAG_W-1:0]     tag_out_raw;

  assign in_ready_o = ~rst_i & ~busy_q[in_sid_i];
  assign accept     = in_valid_i & in_ready_o;
  assign chain_in   = in_first_i ? IV : ctx_q[in_sid_i];

  assign pipe_wb_o = accept ? in_data_i : '0;
  assign {pipe_a0_o, pipe_b0_o, pipe_c0_o, pipe_d0_o} = accept ? chain_in : '0;

  assign tag_in = {accept, in_last_i, in_sid_i};

  md5_tag_delay #(
    .W     (TAG_W),
    .DEPTH (PIPE_LAT)
  ) u_tag_delay (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .tag_i (tag_in),
    .tag_o (tag_out_raw)
  );

  assign tag_out  = tag_out_raw;
  assign exit_sum = ff_add(ctx_q[tag_out.sid], {pipe_a64_i, pipe_b64_i, pipe_c64_i, pipe_d64_i});

  always_comb begin
    ctx_d        = ctx_q;
    busy_d       = busy_q;
    out_valid_d  = 1'b0;
    out_sid_d    = out_sid_q;
    out_digest_d = out_digest_q;
    if (tag_out.valid) begin
      ctx_d[tag_out.sid]  = exit_sum;
      busy_d[tag_out.sid] = 1'b0;
      if (tag_out.last) begin
        out_valid_d  = 1'b1;
        out_sid_d    = tag_out.sid;
        out_digest_d = exit_sum;
      end
    end
    // The exiting stream is still busy, so it can never collide with the accepted one.
    if (accept) begin
      ctx_d[in_sid_i]  = chain_in;
      busy_d[in_sid_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_STREAMS; i++) ctx_q[i] <= IV;
      busy_q       <= '0;
      out_valid_q  <= 1'b0;
      out_sid_q    <= '0;
      out_digest_q <= '0;
    end else begin
      ctx_q        <= ctx_d;
      busy_q       <= busy_d;
      out_valid_q  <= out_valid_d;
      out_sid_q    <= out_sid_d;
      out_digest_q <= out_digest_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_sid_o    = out_sid_q;
  assign out_digest_o = out_digest_q;
  assign busy_o       = busy_q;

`ifdef MD5_SCHED_STATS_EN
  logic [31:0] stat_blocks_q, stat_digests_q, stat_stalls_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_blocks_q  <= '0;
      stat_digests_q <= '0;
      stat_stalls_q  <= '0;
    end else begin
      if (accept)                    stat_blocks_q  <= stat_blocks_q + 32'd1;
      if (out_valid_q)               stat_digests_q <= stat_digests_q + 32'd1;
      if (in_valid_i & ~in_ready_o)  stat_stalls_q  <= stat_stalls_q + 32'd1;
    end
  end

  assign stat_blocks_o  = stat_blocks_q;
  assign stat_digests_o = stat_digests_q;
  assign stat_stalls_o  = stat_stalls_q;
`endif

endmodule
